// File: rtl/regfile_wr_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Register indices used for the hardware exception counters and the zero register.
package regfile_pkg;

    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] XZR_IDX     = 5'd31;
    localparam logic [REG_AW-1:0] EXC_EXT_IDX = 5'd29;
    localparam logic [REG_AW-1:0] EXC_INV_IDX = 5'd30;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_EXT,
        SRC_INV
    } wrSrc_e;

endpackage

// File: rtl/regfile_wr_arb_if.sv
// Bundle between the WB stage / exception logic (master) and the write arbiter (slave).
interface regfile_wr_if import regfile_pkg::*; #(
    parameter int N = 64
);

    logic              wb_we;
    logic [REG_AW-1:0] wb_wa;
    logic [N-1:0]      wb_wd;
    logic              exc_ext;
    logic              exc_inv;
    logic              we3;
    logic [REG_AW-1:0] wa3;
    logic [N-1:0]      wd3;
    logic [N-1:0]      ext_cnt;
    logic [N-1:0]      inv_cnt;
    logic              stall;
    logic [1:0]        pend;

    modport master (
        output wb_we, wb_wa, wb_wd, exc_ext, exc_inv,
        input  we3, wa3, wd3, ext_cnt, inv_cnt, stall, pend
    );

    modport slave (
        input  wb_we, wb_wa, wb_wd, exc_ext, exc_inv,
        output we3, wa3, wd3, ext_cnt, inv_cnt, stall, pend
    );

endinterface

// File: rtl/regfile_wr_arb_exc_counter.sv
// Shadow copy of one exception counter register plus its pending-flush flag.
// With EXC_CNT_SAT_EN defined the counter sticks at all-ones instead of wrapping.
module exc_counter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [N-1:0] load_data_i,
    input  logic         flush_i,
    output logic [N-1:0] cnt_o,
    output logic [N-1:0] cnt_next_o,
    output logic         pend_o
);

    logic [N-1:0] cnt_q, cnt_d, base;
    logic         pend_q, pend_d, incOk;

    // A pipeline load replaces the base value; a same-cycle pulse increments on top of it.
    always_comb begin
        base = load_i ? load_data_i : cnt_q;
`ifdef EXC_CNT_SAT_EN
        incOk = inc_i && (base != {N{1'b1}});
`else
        incOk = inc_i;
`endif
        cnt_d  = base + {{(N-1){1'b0}}, incOk};
        pend_d = incOk || (pend_q && !load_i && !flush_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign pend_o     = pend_q;

endmodule

// File: rtl/regfile_wr_arb.sv
// Sole driver of the regfile write port: merges WB writes with X29/X30 exception-counter flushes.
// Optional macro EXC_CNT_SAT_EN makes the exception counters saturate instead of wrap.
module regfile_wr_arb import regfile_pkg::*; #(
    parameter int N          = 64,
    parameter int STARVE_MAX = 4
) (
    input logic         clk,
    input logic         reset,
    regfile_wr_if.slave bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    wrSrc_e            src;
    logic              wbTake, loadExt, loadInv, flushExt, flushInv;
    logic              pendExt, pendInv;
    logic [N-1:0]      extCnt, invCnt, extNext, invNext;
    logic              we3_q, we3_d, stall_q, stall_d;
    logic [REG_AW-1:0] wa3_q, wa3_d;
    logic [N-1:0]      wd3_q, wd3_d;
    logic [SW-1:0]     starve_q, starve_d;

    // The pipeline always wins the slot; X29 flushes take priority over X30.
    always_comb begin
        wbTake = bus.wb_we && (bus.wb_wa != XZR_IDX);
        src    = SRC_NONE;
        if (wbTake)       src = SRC_WB;
        else if (pendExt) src = SRC_EXT;
        else if (pendInv) src = SRC_INV;
        loadExt  = wbTake && (bus.wb_wa == EXC_EXT_IDX);
        loadInv  = wbTake && (bus.wb_wa == EXC_INV_IDX);
        flushExt = (src == SRC_EXT);
        flushInv = (src == SRC_INV);
    end

    exc_counter #(.N(N)) u_ext (
        .clk(clk), .reset(reset), .inc_i(bus.exc_ext), .load_i(loadExt),
        .load_data_i(bus.wb_wd), .flush_i(flushExt),
        .cnt_o(extCnt), .cnt_next_o(extNext), .pend_o(pendExt)
    );

    exc_counter #(.N(N)) u_inv (
        .clk(clk), .reset(reset), .inc_i(bus.exc_inv), .load_i(loadInv),
        .load_data_i(bus.wb_wd), .flush_i(flushInv),
        .cnt_o(invCnt), .cnt_next_o(invNext), .pend_o(pendInv)
    );

    always_comb begin
        we3_d = 1'b1;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        unique case (src)
            SRC_WB:  begin wa3_d = bus.wb_wa;   wd3_d = bus.wb_wd; end
            SRC_EXT: begin wa3_d = EXC_EXT_IDX; wd3_d = extNext;   end
            SRC_INV: begin wa3_d = EXC_INV_IDX; wd3_d = invNext;   end
            default: we3_d = 1'b0;
        endcase
    end

    // An ignored stall restarts the starvation count from zero.
    always_comb begin
        if (!(pendExt || pendInv) || flushExt || flushInv)
            starve_d = '0;
        else if (wbTake)
            starve_d = (starve_q == SW'(STARVE_MAX)) ? '0 : starve_q + 1'b1;
        else
            starve_d = starve_q;
        stall_d = (starve_d == SW'(STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            stall_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign bus.we3     = we3_q;
    assign bus.wa3     = wa3_q;
    assign bus.wd3     = wd3_q;
    assign bus.ext_cnt = extCnt;
    assign bus.inv_cnt = invCnt;
    assign bus.stall   = stall_q;
    assign bus.pend    = {pendInv, pendExt};

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Self-checking bench for regfile_wr_arb: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_wr_arb;

    localparam int N = 64;
    localparam logic [N-1:0] ONES = {N{1'b1}};
`ifdef EXC_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    regfile_wr_if #(.N(N)) bus ();

    regfile_wr_arb #(.N(N), .STARVE_MAX(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference state, updated from the architectural rules at every rising edge.
    logic [N-1:0] mExt, mInv, mWd;
    logic [4:0]   mWa;
    logic [1:0]   mPend;
    logic         mWe, mStall;
    int           mBlocked;

    task automatic modelStep(input logic we, input logic [4:0] wa, input logic [N-1:0] wd,
                             input logic e, input logic i);
        logic take, incE, incI, flushE, flushI, pe, pi;
        logic [N-1:0] ne, ni;
        take = we && (wa != 5'd31);
        ne = mExt; pe = mPend[0];
        ni = mInv; pi = mPend[1];
        if (take && wa == 5'd29) begin ne = wd; pe = 1'b0; end
        if (take && wa == 5'd30) begin ni = wd; pi = 1'b0; end
        incE = e && !(SAT && ne == ONES);
        incI = i && !(SAT && ni == ONES);
        ne = ne + (incE ? 1 : 0);
        ni = ni + (incI ? 1 : 0);
        flushE = !take && mPend[0];
        flushI = !take && !mPend[0] && mPend[1];
        pe = incE || (pe && !flushE);
        pi = incI || (pi && !flushI);
        if (take)        begin mWe = 1'b1; mWa = wa;    mWd = wd; end
        else if (flushE) begin mWe = 1'b1; mWa = 5'd29; mWd = ne; end
        else if (flushI) begin mWe = 1'b1; mWa = 5'd30; mWd = ni; end
        else             mWe = 1'b0;
        if (mPend == 2'b00 || flushE || flushI) mBlocked = 0;
        else if (take) mBlocked = (mBlocked == 4) ? 0 : mBlocked + 1;
        mStall = (mBlocked == 4);
        mExt = ne; mInv = ni; mPend = {pi, pe};
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [N-1:0] wd,
                                 input logic e, input logic i);
        bus.wb_we = we; bus.wb_wa = wa; bus.wb_wd = wd;
        bus.exc_ext = e; bus.exc_inv = i;
        @(posedge clk);
        modelStep(we, wa, wd, e, i);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.wb_we = 1'b0; bus.wb_wa = '0; bus.wb_wd = '0;
        bus.exc_ext = 1'b0; bus.exc_inv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mExt = '0; mInv = '0; mWd = '0; mWa = '0; mPend = '0;
        mWe = 1'b0; mStall = 1'b0; mBlocked = 0;
    endtask

    task automatic test_reset();
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(1, 5, 64'h1234, 0, 0);
        doReset();
        checks++; if (bus.we3 !== 1'b0)     begin errors++; $display("[TB] FAIL reset_we3: got %0h want 0", bus.we3); end
        checks++; if (bus.wa3 !== 5'd0)     begin errors++; $display("[TB] FAIL reset_wa3: got %0h want 0", bus.wa3); end
        checks++; if (bus.wd3 !== '0)       begin errors++; $display("[TB] FAIL reset_wd3: got %0h want 0", bus.wd3); end
        checks++; if (bus.ext_cnt !== '0)   begin errors++; $display("[TB] FAIL reset_ext: got %0h want 0", bus.ext_cnt); end
        checks++; if (bus.inv_cnt !== '0)   begin errors++; $display("[TB] FAIL reset_inv: got %0h want 0", bus.inv_cnt); end
        checks++; if (bus.stall !== 1'b0)   begin errors++; $display("[TB] FAIL reset_stall: got %0h want 0", bus.stall); end
        checks++; if (bus.pend !== 2'b00)   begin errors++; $display("[TB] FAIL reset_pend: got %0b want 00", bus.pend); end
    endtask

    task automatic test_ext_flush();
        doReset();
        applyStimulus(0, 0, 0, 1, 0);
        checks++; if (bus.ext_cnt !== 64'd1) begin errors++; $display("[TB] FAIL ext_inc_cnt: got %0h want 1", bus.ext_cnt); end
        checks++; if (bus.pend !== 2'b01)    begin errors++; $display("[TB] FAIL ext_inc_pend: got %0b want 01", bus.pend); end
        checks++; if (bus.we3 !== 1'b0)      begin errors++; $display("[TB] FAIL ext_inc_we3: got %0h want 0", bus.we3); end
        applyStimulus(0, 0, 0, 0, 0);
        checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd29 || bus.wd3 !== 64'd1)
            begin errors++; $display("[TB] FAIL ext_flush_write: got we=%0h wa=%0d wd=%0h want we=1 wa=29 wd=1", bus.we3, bus.wa3, bus.wd3); end
        checks++; if (bus.pend !== 2'b00)    begin errors++; $display("[TB] FAIL ext_flush_pend: got %0b want 00", bus.pend); end
    endtask

    task automatic test_wb_priority();
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 5, 64'hAB, 0, (c == 0));
            checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd5 || bus.wd3 !== 64'hAB)
                begin errors++; $display("[TB] FAIL wb_pass_%0d: got we=%0h wa=%0d wd=%0h want we=1 wa=5 wd=ab", c, bus.we3, bus.wa3, bus.wd3); end
        end
        checks++; if (bus.pend !== 2'b10 || bus.inv_cnt !== 64'd1)
            begin errors++; $display("[TB] FAIL wb_inv_pending: got pend=%0b inv=%0h want pend=10 inv=1", bus.pend, bus.inv_cnt); end
        applyStimulus(0, 0, 0, 0, 0);
        checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd30 || bus.wd3 !== 64'd1)
            begin errors++; $display("[TB] FAIL inv_flush_write: got we=%0h wa=%0d wd=%0h want we=1 wa=30 wd=1", bus.we3, bus.wa3, bus.wd3); end
    endtask

    task automatic test_starve();
        int seen;
        doReset();
        applyStimulus(1, 7, 64'h55, 1, 0);
        seen = -1;
        for (int k = 1; k <= 12 && seen < 0; k++) begin
            applyStimulus(1, 7, 64'h55, 0, 0);
            if (bus.stall === 1'b1) seen = k;
        end
        checks++; if (seen != 4) begin errors++; $display("[TB] FAIL starve_stall_cycle: got %0d want 4", seen); end
        applyStimulus(0, 7, 64'h55, 0, 0);
        checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd29 || bus.wd3 !== 64'd1)
            begin errors++; $display("[TB] FAIL starve_flush: got we=%0h wa=%0d wd=%0h want we=1 wa=29 wd=1", bus.we3, bus.wa3, bus.wd3); end
        checks++; if (bus.stall !== 1'b0 || bus.pend !== 2'b00)
            begin errors++; $display("[TB] FAIL starve_after: got stall=%0h pend=%0b want stall=0 pend=00", bus.stall, bus.pend); end
    endtask

    task automatic test_wb_collision();
        doReset();
        applyStimulus(1, 29, 64'd100, 1, 0);
        checks++; if (bus.ext_cnt !== 64'd101 || bus.pend !== 2'b01)
            begin errors++; $display("[TB] FAIL coll_counter: got ext=%0d pend=%0b want ext=101 pend=01", bus.ext_cnt, bus.pend); end
        checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd29 || bus.wd3 !== 64'd100)
            begin errors++; $display("[TB] FAIL coll_wb_write: got we=%0h wa=%0d wd=%0d want we=1 wa=29 wd=100", bus.we3, bus.wa3, bus.wd3); end
        applyStimulus(0, 0, 0, 0, 0);
        checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd29 || bus.wd3 !== 64'd101)
            begin errors++; $display("[TB] FAIL coll_flush: got we=%0h wa=%0d wd=%0d want we=1 wa=29 wd=101", bus.we3, bus.wa3, bus.wd3); end
    endtask

    task automatic test_xzr();
        doReset();
        applyStimulus(1, 31, 64'hFF, 0, 0);
        checks++; if (bus.we3 !== 1'b0 || bus.wa3 !== 5'd0 || bus.wd3 !== '0)
            begin errors++; $display("[TB] FAIL xzr_no_write: got we=%0h wa=%0d wd=%0h want we=0 wa=0 wd=0", bus.we3, bus.wa3, bus.wd3); end
    endtask

    task automatic test_simultaneous();
        doReset();
        applyStimulus(0, 0, 0, 1, 1);
        checks++; if (bus.pend !== 2'b11 || bus.ext_cnt !== 64'd1 || bus.inv_cnt !== 64'd1)
            begin errors++; $display("[TB] FAIL simul_inc: got pend=%0b ext=%0h inv=%0h want 11/1/1", bus.pend, bus.ext_cnt, bus.inv_cnt); end
        applyStimulus(0, 0, 0, 0, 0);
        checks++; if (bus.wa3 !== 5'd29 || bus.pend !== 2'b10)
            begin errors++; $display("[TB] FAIL simul_first: got wa=%0d pend=%0b want wa=29 pend=10", bus.wa3, bus.pend); end
        applyStimulus(0, 0, 0, 0, 0);
        checks++; if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd30 || bus.wd3 !== 64'd1 || bus.pend !== 2'b00)
            begin errors++; $display("[TB] FAIL simul_second: got we=%0h wa=%0d wd=%0h pend=%0b want 1/30/1/00", bus.we3, bus.wa3, bus.wd3, bus.pend); end
    endtask

    task automatic test_wrap_sat();
        doReset();
        applyStimulus(1, 29, ONES, 0, 0);
        checks++; if (bus.ext_cnt !== ONES || bus.wd3 !== ONES)
            begin errors++; $display("[TB] FAIL preload_ones: got ext=%0h wd=%0h want all-ones", bus.ext_cnt, bus.wd3); end
        applyStimulus(0, 0, 0, 1, 0);
`ifdef EXC_CNT_SAT_EN
        checks++; if (bus.ext_cnt !== ONES || bus.pend !== 2'b00)
            begin errors++; $display("[TB] FAIL sat_hold: got ext=%0h pend=%0b want all-ones/00", bus.ext_cnt, bus.pend); end
`else
        checks++; if (bus.ext_cnt !== '0 || bus.pend !== 2'b01)
            begin errors++; $display("[TB] FAIL wrap_zero: got ext=%0h pend=%0b want 0/01", bus.ext_cnt, bus.pend); end
`endif
    endtask

    task automatic test_random();
        logic         we, e, i;
        logic [4:0]   wa;
        logic [N-1:0] wd;
        doReset();
        for (int c = 0; c < 400; c++) begin
            we = ($urandom_range(0, 3) != 0);
            if (mStall && $urandom_range(0, 3) != 0) we = 1'b0;
            case ($urandom_range(0, 4))
                0: wa = 5'd29;
                1: wa = 5'd30;
                2: wa = 5'd31;
                default: wa = 5'($urandom);
            endcase
            wd = ($urandom_range(0, 5) == 0) ? ONES - N'($urandom_range(0, 2)) : {32'($urandom), 32'($urandom)};
            e = ($urandom_range(0, 2) == 0);
            i = ($urandom_range(0, 2) == 0);
            applyStimulus(we, wa, wd, e, i);
            checks++; if (bus.we3 !== mWe)       begin errors++; $display("[TB] FAIL rnd_we3 c=%0d: got %0h want %0h", c, bus.we3, mWe); end
            checks++; if (bus.wa3 !== mWa)       begin errors++; $display("[TB] FAIL rnd_wa3 c=%0d: got %0d want %0d", c, bus.wa3, mWa); end
            checks++; if (bus.wd3 !== mWd)       begin errors++; $display("[TB] FAIL rnd_wd3 c=%0d: got %0h want %0h", c, bus.wd3, mWd); end
            checks++; if (bus.ext_cnt !== mExt)  begin errors++; $display("[TB] FAIL rnd_ext c=%0d: got %0h want %0h", c, bus.ext_cnt, mExt); end
            checks++; if (bus.inv_cnt !== mInv)  begin errors++; $display("[TB] FAIL rnd_inv c=%0d: got %0h want %0h", c, bus.inv_cnt, mInv); end
            checks++; if (bus.pend !== mPend)    begin errors++; $display("[TB] FAIL rnd_pend c=%0d: got %0b want %0b", c, bus.pend, mPend); end
            checks++; if (bus.stall !== mStall)  begin errors++; $display("[TB] FAIL rnd_stall c=%0d: got %0h want %0h", c, bus.stall, mStall); end
        end
    endtask

    // Directed scenarios first, then a randomized soak against the reference model.
    initial begin
        doReset();
        test_reset();
        test_ext_flush();
        test_wb_priority();
        test_starve();
        test_wb_collision();
        test_xzr();
        test_simultaneous();
        test_wrap_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
